// File: rtl/rom_responder_if.sv
// rtl/rom_responder_if.sv - CPU nibble bus and ROM array signals of the ROM responder
interface rom_responder_if;
    logic       sync;
    logic [3:0] bus_in;
    logic [7:0] mem_addr;
    logic       mem_req;
    logic [7:0] mem_rdata;
    logic [3:0] bus_out;
    logic       bus_oe;
    logic       fetch_hit;

    modport slave (
        input  sync,
        input  bus_in,
        input  mem_rdata,
        output mem_addr,
        output mem_req,
        output bus_out,
        output bus_oe,
        output fetch_hit
    );

    modport master (
        output sync,
        output bus_in,
        output mem_rdata,
        input  mem_addr,
        input  mem_req,
        input  bus_out,
        input  bus_oe,
        input  fetch_hit
    );
endinterface

// File: rtl/rom_responder.sv
// rtl/rom_responder.sv - instruction ROM responder for an 8-cycle nibble bus
// Tracks the bus cycle, fetches one ROM byte per instruction and drives OPR/OPA when selected.
module rom_responder #(
    parameter logic [3:0] CHIP_ID = 4'h0
) (
    input  logic              clock,
    input  logic              reset,
    rom_responder_if.slave    bus
);

    typedef enum logic [2:0] {
        CYC_A1 = 3'd0,
        CYC_A2 = 3'd1,
        CYC_A3 = 3'd2,
        CYC_M1 = 3'd3,
        CYC_M2 = 3'd4,
        CYC_X1 = 3'd5,
        CYC_X2 = 3'd6,
        CYC_X3 = 3'd7
    } cycle_e;

    cycle_e     cycle_q, cycle_d;
    logic       locked_q, locked_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] instr_q, instr_d;
    logic       selected_q, selected_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_q    <= CYC_A1;
            locked_q   <= 1'b0;
            mem_addr_q <= 8'h00;
            instr_q    <= 8'h00;
            selected_q <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            locked_q   <= locked_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
            selected_q <= selected_d;
        end
    end

    // Sync wins over everything: it aborts any fetch in flight by returning to A1
    // with selected cleared, so the aborted instruction never reaches M1/M2 drive.
    always_comb begin
        cycle_d    = cycle_q;
        locked_d   = locked_q;
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        selected_d = selected_q;
        if (bus.sync) begin
            cycle_d    = CYC_A1;
            locked_d   = 1'b1;
            selected_d = 1'b0;
        end else if (locked_q) begin
            case (cycle_q)
                CYC_A1: begin
                    mem_addr_d[3:0] = bus.bus_in;
                    cycle_d         = CYC_A2;
                end
                CYC_A2: begin
                    mem_addr_d[7:4] = bus.bus_in;
                    cycle_d         = CYC_A3;
                end
                CYC_A3: begin
                    instr_d    = bus.mem_rdata;
                    selected_d = (bus.bus_in == CHIP_ID);
                    cycle_d    = CYC_M1;
                end
                CYC_M1: cycle_d = CYC_M2;
                CYC_M2: cycle_d = CYC_X1;
                CYC_X1: cycle_d = CYC_X2;
                CYC_X2: cycle_d = CYC_X3;
                CYC_X3: begin
                    selected_d = 1'b0;
                    cycle_d    = CYC_A1;
                end
                default: begin
                    selected_d = 1'b0;
                    cycle_d    = CYC_A1;
                end
            endcase
        end
    end

    always_comb begin
        bus.mem_addr  = mem_addr_q;
        bus.mem_req   = locked_q && (cycle_q == CYC_A3);
        bus.bus_oe    = locked_q && selected_q && ((cycle_q == CYC_M1) || (cycle_q == CYC_M2));
        bus.fetch_hit = locked_q && selected_q && (cycle_q == CYC_M2);
        bus.bus_out   = 4'h0;
        if (bus.bus_oe) begin
            bus.bus_out = (cycle_q == CYC_M1) ? instr_q[7:4] : instr_q[3:0];
        end
    end

endmodule

// File: tb/tb_rom_responder.sv
// tb/tb_rom_responder.sv - directed self-checking bench for rom_responder
module tb_rom_responder;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [7:0] rom [256];

    rom_responder_if bus_if ();

    assign bus_if.mem_rdata = rom[bus_if.mem_addr];

    rom_responder #(.CHIP_ID(4'h2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic req, input logic oe,
                           input logic [3:0] out, input logic hit);
        chk({tag, " mem_req"},   {7'd0, bus_if.mem_req},   {7'd0, req});
        chk({tag, " bus_oe"},    {7'd0, bus_if.bus_oe},    {7'd0, oe});
        chk({tag, " bus_out"},   {4'd0, bus_if.bus_out},   {4'd0, out});
        chk({tag, " fetch_hit"}, {7'd0, bus_if.fetch_hit}, {7'd0, hit});
    endtask

    task automatic tick(input logic s, input logic [3:0] b);
        bus_if.sync   = s;
        bus_if.bus_in = b;
        @(posedge clock);
        #1;
    endtask

    // Starts in A1, ends back in A1 one full 8-cycle instruction later.
    task automatic fetch(input string tag, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [3:0] a3, input logic [7:0] exp_addr, input logic exp_oe,
                         input logic [3:0] opr, input logic [3:0] opa);
        tick(1'b0, a1);
        tick(1'b0, a2);
        chk_bus({tag, " A3"}, 1'b1, 1'b0, 4'h0, 1'b0);
        chk({tag, " A3 mem_addr"}, bus_if.mem_addr, exp_addr);
        tick(1'b0, a3);
        chk_bus({tag, " M1"}, 1'b0, exp_oe, exp_oe ? opr : 4'h0, 1'b0);
        tick(1'b0, 4'($urandom_range(0, 15)));
        chk_bus({tag, " M2"}, 1'b0, exp_oe, exp_oe ? opa : 4'h0, exp_oe);
        tick(1'b0, 4'($urandom_range(0, 15)));
        chk_bus({tag, " X1"}, 1'b0, 1'b0, 4'h0, 1'b0);
        tick(1'b0, 4'($urandom_range(0, 15)));
        tick(1'b0, 4'($urandom_range(0, 15)));
        tick(1'b0, 4'($urandom_range(0, 15)));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) rom[i] = 8'hEE;
        rom[8'hA5] = 8'hD3;
        rom[8'h00] = 8'h1E;
        rom[8'hFF] = 8'hC7;
        rom[8'h10] = 8'h94;
        rom[8'h3C] = 8'h6B;

        reset         = 1'b0;
        bus_if.sync   = 1'b0;
        bus_if.bus_in = 4'h0;
        repeat (2) @(posedge clock);
        #1;
        chk_bus("reset", 1'b0, 1'b0, 4'h0, 1'b0);
        chk("reset mem_addr", bus_if.mem_addr, 8'h00);
        #2 reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 4'($urandom_range(0, 15)));
            chk_bus("nosync", 1'b0, 1'b0, 4'h0, 1'b0);
        end
        chk("nosync mem_addr", bus_if.mem_addr, 8'h00);

        tick(1'b1, 4'h0);
        fetch("hit A5", 4'h5, 4'hA, 4'h2, 8'hA5, 1'b1, 4'hD, 4'h3);

        tick(1'b1, 4'h0);
        fetch("miss A5", 4'h5, 4'hA, 4'h7, 8'hA5, 1'b0, 4'h0, 4'h0);

        tick(1'b1, 4'h0);
        fetch("run 00", 4'h0, 4'h0, 4'h2, 8'h00, 1'b1, 4'h1, 4'hE);
        fetch("run FF", 4'hF, 4'hF, 4'h2, 8'hFF, 1'b1, 4'hC, 4'h7);
        fetch("run 10", 4'h0, 4'h1, 4'h2, 8'h10, 1'b1, 4'h9, 4'h4);

        tick(1'b1, 4'h0);
        tick(1'b0, 4'h5);
        tick(1'b0, 4'hA);
        tick(1'b0, 4'h2);
        chk_bus("abort M1", 1'b0, 1'b1, 4'hD, 1'b0);
        tick(1'b1, 4'h0);
        chk_bus("abort A1", 1'b0, 1'b0, 4'h0, 1'b0);
        fetch("after abort", 4'hC, 4'h3, 4'h2, 8'h3C, 1'b1, 4'h6, 4'hB);

        tick(1'b1, 4'h0);
        tick(1'b0, 4'h5);
        #3 reset = 1'b0;
        #1;
        chk_bus("async reset", 1'b0, 1'b0, 4'h0, 1'b0);
        chk("async reset mem_addr", bus_if.mem_addr, 8'h00);
        #2 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 4'($urandom_range(0, 15)));
            chk_bus("post reset", 1'b0, 1'b0, 4'h0, 1'b0);
        end
        tick(1'b1, 4'h0);
        fetch("resume A5", 4'h5, 4'hA, 4'h2, 8'hA5, 1'b1, 4'hD, 4'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_responder.md
ROM_RESPONDER -- requirements
Module: rom_responder

Interface
REQ-001 The module SHALL have parameter CHIP_ID, default 4'h0, the value the A3 address nibble must equal for this block to respond.
REQ-002 clock  input  1  single clock; all state SHALL change on its rising edge only, except on reset.
REQ-003 reset  input  1  asynchronous, active-low reset; low SHALL immediately force the reset state.
REQ-004 sync  input  1  high for one clock while the bus is in X3; the next clock is A1.
REQ-005 bus_in  input  4  bus nibble driven by the CPU in A1, A2 and A3.
REQ-006 mem_addr  output  8  ROM byte address {A2 nibble, A1 nibble}, registered.
REQ-007 mem_req  output  1  read strobe to the ROM array.
REQ-008 mem_rdata  input  8  ROM byte; valid within the cycle mem_req is high.
REQ-009 bus_out  output  4  nibble this block drives in M1 and M2.
REQ-010 bus_oe  output  1  high when bus_out is valid and must be driven.
REQ-011 fetch_hit  output  1  one-clock pulse in M2 of each instruction this block served.

Function
REQ-012 The block SHALL hold a 3-bit cycle state: A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7, plus a 1-bit "locked" flag.
REQ-013 Before the first sync after reset, locked=0; the cycle state SHALL hold, and bus_oe, mem_req and fetch_hit SHALL stay 0.
REQ-014 When sync is 1 at a rising edge, the next cycle SHALL be A1 and locked SHALL be set, from any current state.
REQ-015 When locked=1 and sync=0, the cycle SHALL advance by 1 each clock, wrapping X3->A1 (free-running, no sync required).
REQ-016 Sync sampled in any state other than X3 SHALL resynchronise to A1 and abort the fetch in progress: no M1/M2 drive for the aborted instruction.
REQ-017 In A1, bus_in SHALL be captured into mem_addr[3:0] at the edge leaving A1.
REQ-018 In A2, bus_in SHALL be captured into mem_addr[7:4] at the edge leaving A2.
REQ-019 In A3, mem_req SHALL be 1 with mem_addr stable; mem_req SHALL be 0 in all other cycles.
REQ-020 At the edge leaving A3, mem_rdata SHALL be latched into an 8-bit instruction register.
REQ-021 At the same edge, the "selected" flag SHALL be set if bus_in==CHIP_ID, and cleared otherwise.
REQ-022 In M1, bus_out SHALL be instr[7:4] (OPR); in M2, bus_out SHALL be instr[3:0] (OPA).
REQ-023 bus_oe SHALL be 1 only in M1 and M2 with selected=1; it is combinational from the cycle state and selected.
REQ-024 bus_out SHALL be 4'h0 whenever bus_oe=0.
REQ-025 fetch_hit SHALL be 1 exactly during M2 when selected=1.
REQ-026 X1-X3 SHALL drive nothing; selected SHALL clear on entry to A1.
REQ-027 Address arithmetic SHALL have no carry between nibbles: mem_addr is a pure concatenation, 8'hFF is valid, and there is no wrap handling.

Reset
REQ-028 Asserting reset (low) at any time, including mid-fetch, SHALL immediately force: cycle=A1, locked=0, mem_addr=8'h00, instr=8'h00, selected=0.
REQ-029 While reset is asserted, outputs SHALL be bus_out=4'h0, bus_oe=0, mem_req=0, fetch_hit=0.
REQ-030 After reset deasserts, the block SHALL wait for sync per REQ-013.

Verification
REQ-031 CHIP_ID=2; sync, then A1=4'h5, A2=4'hA, A3=4'h2, ROM[0xA5]=8'hD3 -> mem_req=1 in A3 with mem_addr=8'hA5; M1 bus_out=4'hD with oe=1; M2 bus_out=4'h3 with oe=1 and fetch_hit=1.
REQ-032 Same sequence but A3=4'h7 -> mem_req pulses; bus_oe=0, bus_out=0 and fetch_hit=0 throughout.
REQ-033 Three back-to-back instructions with sync only before the first, at addresses 0x00, 0xFF, 0x10 -> free-running wrap; each is fetched and driven correctly, including the 8'hFF address.
REQ-034 Sync asserted during M1 of a selected fetch -> next cycle is A1, no M2 drive, no fetch_hit; the following instruction is served normally.
REQ-035 Reset pulsed low asynchronously mid-A2, then released, with bus activity present but no sync -> outputs stay 0 until the next sync, then normal fetch resumes.
REQ-036 No sync after reset for 20 clocks with random bus_in -> mem_req, bus_oe and fetch_hit remain 0.
